// File: rtl/pixel_rx_pkg.sv
// pixel_rx_pkg
// Shared definitions for the pixel receiver: the per-byte receive state
// enumeration, the 8N1 frame constants and a small shift helper.
package pixel_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

  // Serial data arrives LSB first: each new bit enters at the MSB end and
  // after eight shifts the first bit received sits in bit 0.
  function automatic logic [7:0] shift_in_lsb_first(input logic [7:0] cur,
                                                    input logic       bit_in);
    return {bit_in, cur[7:1]};
  endfunction

endpackage

// File: rtl/pixel_rx_byte.sv
// uart_rx_byte
// Receives one 8N1 byte from an already synchronized serial line.
// Ports:
//   clock       system clock (rising edge)
//   reset_n     synchronous active-low reset
//   rx_sync     synchronized serial line, idles high
//   byte_out    last shifted-in byte (complete when byte_valid is high)
//   byte_valid  combinational strobe: stop sample was high this cycle
//   frame_err   combinational strobe: stop sample was low this cycle
//   active      registered, high while a frame is in progress
module uart_rx_byte
  import pixel_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2604
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx_sync,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       active
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  // Timer counts down to zero; a sample is taken in the cycle it reads zero.
  localparam logic [CW-1:0] HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] TMR_ZERO    = {CW{1'b0}};
  localparam logic [2:0]    LAST_DATA   = 3'(DATA_BITS - 1);
  localparam logic [2:0]    LAST_STOP   = 3'(STOP_BITS - 1);

  rx_state_e     state_q, state_d;
  logic [CW-1:0] tmr_q, tmr_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          rx_prev_q;
  logic          active_q, active_d;
  logic          sample_s;
  logic          valid_s;
  logic          ferr_s;

  assign sample_s = (tmr_q == TMR_ZERO);

  // Next-state, timer reload, bit counting and byte strobes.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    valid_s = 1'b0;
    ferr_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Edge detection on the previous sample means a line stuck low after
        // a framing error cannot restart until it has been seen high again.
        if (rx_prev_q && !rx_sync) begin
          state_d = ST_START;
          tmr_d   = HALF_RELOAD;
          bit_d   = 3'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (sample_s) begin
          if (rx_sync) begin
            state_d = ST_IDLE;        // glitch: nothing reported
            tmr_d   = TMR_ZERO;
          end else begin
            state_d = ST_DATA;
            tmr_d   = FULL_RELOAD;
          end
        end else begin
          tmr_d = tmr_q - {{(CW-1){1'b0}}, 1'b1};
        end
      end
      ST_DATA: begin
        if (sample_s) begin
          shreg_d = shift_in_lsb_first(shreg_q, rx_sync);
          tmr_d   = FULL_RELOAD;
          if (bit_q == LAST_DATA) begin
            state_d = ST_STOP;
            bit_d   = 3'd0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          tmr_d = tmr_q - {{(CW-1){1'b0}}, 1'b1};
        end
      end
      ST_STOP: begin
        if (sample_s) begin
          if (!rx_sync) begin
            ferr_s  = 1'b1;
            state_d = ST_IDLE;
            tmr_d   = TMR_ZERO;
            bit_d   = 3'd0;
          end else if (bit_q == LAST_STOP) begin
            valid_s = 1'b1;
            state_d = ST_IDLE;
            tmr_d   = TMR_ZERO;
            bit_d   = 3'd0;
          end else begin
            bit_d = bit_q + 3'd1;
            tmr_d = FULL_RELOAD;
          end
        end else begin
          tmr_d = tmr_q - {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = ST_IDLE;
        tmr_d   = TMR_ZERO;
        bit_d   = 3'd0;
      end
    endcase
    active_d = (state_d != ST_IDLE);
  end

  // State, counters, shift register and edge-detect history.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      tmr_q     <= TMR_ZERO;
      bit_q     <= 3'd0;
      shreg_q   <= 8'd0;
      rx_prev_q <= 1'b1;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      rx_prev_q <= rx_sync;
      active_q  <= active_d;
    end
  end

  assign byte_out   = shreg_q;
  assign byte_valid = valid_s;
  assign frame_err  = ferr_s;
  assign active     = active_q;

endmodule

// File: rtl/pixel_rx.sv
// pixel_rx
// Receives BPP consecutive 8N1 bytes and presents them as one pixel word,
// first byte in the least significant lane.
// Ports:
//   clock        system clock (rising edge)
//   reset_n      synchronous active-low reset
//   data_rx      asynchronous serial input, idles high
//   data_out     last complete pixel (held between done pulses)
//   done_flag    one-cycle pulse when data_out updates
//   active_flag  high while a byte frame is in progress
//   error_flag   one-cycle pulse on a framing error
module pixel_rx
  import pixel_rx_pkg::*;
#(
  parameter int BPP          = 3,
  parameter int SZ           = 8 * BPP,
  parameter int CLKS_PER_BIT = 2604
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          data_rx,
  output logic [SZ-1:0] data_out,
  output logic          done_flag,
  output logic          active_flag,
  output logic          error_flag
);

  localparam int BCW = (BPP > 1) ? $clog2(BPP) : 1;
  localparam logic [BCW-1:0] LAST_LANE = BCW'(BPP - 1);

  logic           sync1_q, sync2_q;
  logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
  logic [SZ-1:0]  pix_q, pix_d;
  logic [SZ-1:0]  data_q, data_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic [7:0]     byte_s;
  logic           byte_valid_s;
  logic           frame_err_s;
  logic           active_s;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clock     (clock),
    .reset_n   (reset_n),
    .rx_sync   (sync2_q),
    .byte_out  (byte_s),
    .byte_valid(byte_valid_s),
    .frame_err (frame_err_s),
    .active    (active_s)
  );

  // Pixel assembly: place each byte in its lane, publish on the last lane.
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    pix_d      = pix_q;
    data_d     = data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    if (frame_err_s) begin
      byte_cnt_d = {BCW{1'b0}};
      pix_d      = {SZ{1'b0}};
      err_d      = 1'b1;
    end else if (byte_valid_s) begin
      for (int i = 0; i < BPP; i++) begin
        if (byte_cnt_q == BCW'(i)) begin
          pix_d[8*i +: 8] = byte_s;
        end else begin
          pix_d[8*i +: 8] = pix_q[8*i +: 8];
        end
      end
      if (byte_cnt_q == LAST_LANE) begin
        data_d     = pix_d;
        done_d     = 1'b1;
        byte_cnt_d = {BCW{1'b0}};
      end else begin
        byte_cnt_d = byte_cnt_q + {{(BCW-1){1'b0}}, 1'b1};
      end
    end else begin
      byte_cnt_d = byte_cnt_q;
    end
  end

  // Input synchronizer, byte counter, partial pixel and output registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      byte_cnt_q <= {BCW{1'b0}};
      pix_q      <= {SZ{1'b0}};
      data_q     <= {SZ{1'b0}};
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sync1_q    <= data_rx;
      sync2_q    <= sync1_q;
      byte_cnt_q <= byte_cnt_d;
      pix_q      <= pix_d;
      data_q     <= data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign data_out    = data_q;
  assign done_flag   = done_q;
  assign error_flag  = err_q;
  assign active_flag = active_s;

endmodule

// File: tb/tb_pixel_rx.sv
module tb_pixel_rx;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx16    = 1'b1;
  logic        rx17    = 1'b1;
  logic [23:0] data16, data17;
  logic        done16, act16, err16;
  logic        done17, act17, err17;

  always #5 clock = ~clock;

  pixel_rx #(.BPP(3), .SZ(24), .CLKS_PER_BIT(16)) u_dut16 (
    .clock(clock), .reset_n(reset_n), .data_rx(rx16), .data_out(data16),
    .done_flag(done16), .active_flag(act16), .error_flag(err16)
  );

  pixel_rx #(.BPP(3), .SZ(24), .CLKS_PER_BIT(17)) u_dut17 (
    .clock(clock), .reset_n(reset_n), .data_rx(rx17), .data_out(data17),
    .done_flag(done17), .active_flag(act17), .error_flag(err17)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [23:0] q16[$];
  logic [23:0] q17[$];
  int          done_cnt16 = 0, err_cnt16 = 0, done_cnt17 = 0, err_cnt17 = 0;
  logic        act_seen16 = 1'b0;
  logic        done16_prev = 1'b0, done17_prev = 1'b0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: every done pulse pops one expected pixel.
  always @(negedge clock) begin
    if (reset_n) begin
      if (done16) begin
        done_cnt16++;
        chk_eq("done16_width", {31'd0, done16_prev}, 32'd0);
        chk_eq("done16_pending", {31'd0, q16.size() > 0}, 32'd1);
        if (q16.size() > 0) chk_eq("pixel16", {8'd0, data16}, {8'd0, q16.pop_front()});
      end
      if (done17) begin
        done_cnt17++;
        chk_eq("done17_width", {31'd0, done17_prev}, 32'd0);
        chk_eq("done17_pending", {31'd0, q17.size() > 0}, 32'd1);
        if (q17.size() > 0) chk_eq("pixel17", {8'd0, data17}, {8'd0, q17.pop_front()});
      end
      if (err16) err_cnt16++;
      if (err17) err_cnt17++;
      if (act16) act_seen16 = 1'b1;
    end
    done16_prev = done16;
    done17_prev = done17;
  end

  task automatic drive(input int which, input logic v, input int n);
    if (which == 0) rx16 = v;
    else rx17 = v;
    repeat (n) @(negedge clock);
  endtask

  task automatic send_byte(input int which, input logic [7:0] b, input logic stop_bit,
                           input int gap_bits);
    int cpb;
    cpb = (which == 0) ? 16 : 17;
    drive(which, 1'b0, cpb);
    for (int i = 0; i < 8; i++) drive(which, b[i], cpb);
    drive(which, stop_bit, cpb);
    drive(which, 1'b1, gap_bits * cpb);
  endtask

  task automatic send_pixel(input int which, input logic [23:0] pix, input int gap_bits);
    if (which == 0) q16.push_back(pix);
    else q17.push_back(pix);
    for (int k = 0; k < 3; k++) send_byte(which, pix[8*k +: 8], 1'b1, gap_bits);
  endtask

  task automatic wait_drain(input int which);
    for (int i = 0; i < 2000; i++) begin
      if (((which == 0) ? q16.size() : q17.size()) == 0) break;
      @(negedge clock);
    end
    chk_eq("drain", (which == 0) ? q16.size() : q17.size(), 32'd0);
  endtask

  int d0, e0;

  initial begin
    // Reset state
    repeat (3) @(negedge clock);
    chk_eq("reset_data16", {8'd0, data16}, 32'd0);
    chk_eq("reset_data17", {8'd0, data17}, 32'd0);
    chk_eq("reset_flags16", {29'd0, done16, act16, err16}, 32'd0);
    chk_eq("reset_flags17", {29'd0, done17, act17, err17}, 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);

    // Basic pixel with inter-byte gaps
    d0 = done_cnt16; e0 = err_cnt16;
    send_pixel(0, 24'h0F3CA5, 5);
    wait_drain(0);
    chk_eq("basic_done", done_cnt16 - d0, 32'd1);
    chk_eq("basic_err", err_cnt16 - e0, 32'd0);
    chk_eq("basic_data", {8'd0, data16}, 32'h000F3CA5);

    // Short low glitch on an idle line
    d0 = done_cnt16; e0 = err_cnt16; act_seen16 = 1'b0;
    drive(0, 1'b0, 4);
    drive(0, 1'b1, 40);
    chk_eq("glitch_active_seen", {31'd0, act_seen16}, 32'd1);
    chk_eq("glitch_active_low", {31'd0, act16}, 32'd0);
    chk_eq("glitch_done", done_cnt16 - d0, 32'd0);
    chk_eq("glitch_err", err_cnt16 - e0, 32'd0);
    send_pixel(0, 24'h112233, 1);
    wait_drain(0);
    chk_eq("post_glitch_data", {8'd0, data16}, 32'h00112233);

    // Framing error on the second byte
    d0 = done_cnt16; e0 = err_cnt16;
    send_byte(0, 8'h12, 1'b1, 2);
    send_byte(0, 8'h34, 1'b0, 2);
    chk_eq("ferr_err", err_cnt16 - e0, 32'd1);
    chk_eq("ferr_done", done_cnt16 - d0, 32'd0);
    chk_eq("ferr_data_held", {8'd0, data16}, 32'h00112233);
    send_pixel(0, 24'hABCDEF, 1);
    wait_drain(0);
    chk_eq("post_ferr_data", {8'd0, data16}, 32'h00ABCDEF);

    // Back-to-back frames, no idle between them
    d0 = done_cnt16; e0 = err_cnt16;
    send_pixel(0, 24'h010203, 0);
    send_pixel(0, 24'hFEDCBA, 0);
    drive(0, 1'b1, 32);
    wait_drain(0);
    chk_eq("b2b_done", done_cnt16 - d0, 32'd2);
    chk_eq("b2b_err", err_cnt16 - e0, 32'd0);

    // Reset during the data bits of byte 1
    send_byte(0, 8'h77, 1'b1, 1);
    d0 = done_cnt16; e0 = err_cnt16;
    fork
      send_byte(0, 8'hFF, 1'b1, 3);
      begin
        repeat (16 * 3) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        chk_eq("midreset_data", {8'd0, data16}, 32'd0);
        chk_eq("midreset_flags", {29'd0, done16, act16, err16}, 32'd0);
        reset_n = 1'b1;
      end
    join
    chk_eq("midreset_done", done_cnt16 - d0, 32'd0);
    chk_eq("midreset_err", err_cnt16 - e0, 32'd0);
    send_pixel(0, 24'h5A5A5A, 1);
    wait_drain(0);
    chk_eq("post_reset_data", {8'd0, data16}, 32'h005A5A5A);

    // Odd bit period
    d0 = done_cnt17; e0 = err_cnt17;
    send_pixel(1, 24'hC3C3C3, 0);
    drive(1, 1'b1, 34);
    wait_drain(1);
    chk_eq("odd_done", done_cnt17 - d0, 32'd1);
    chk_eq("odd_err", err_cnt17 - e0, 32'd0);
    chk_eq("odd_data", {8'd0, data17}, 32'h00C3C3C3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
